bus_dev_endpoint: RTL and testbench

Device-side endpoint for the `bs_gnrtr_n_rbtr` bus: the far end of one driver slot. It presents outgoing packets to the bus through `pndng`/`D_pop` and releases them on `pop`. It captures incoming packets from `push`/`D_push` into a receive queue for the local host. One instance sits at each of the `drvrs` bus ports and replaces the behavioural driver/monitor FIFO with synthesizable RTL.

---
 rtl/bus_ep_pkg.sv | 13 +
 rtl/bus_ep_if.sv | 27 ++
 rtl/bus_ep_fifo.sv | 55 +++++
 rtl/bus_dev_endpoint.sv | 71 +++++++
 tb/tb_bus_dev_endpoint.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_ep_pkg.sv
// Shared constants and helpers for the bus device endpoint, its bus and its bench.
package bus_ep_pkg;

    localparam int ID_W  = 8;
    localparam int PKT_W = 16;
    localparam logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}};

    // Destination id lives in the top ID_W bits of a packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_W-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_ep_if.sv
// Host and bus signals of one endpoint; slave = endpoint view, master = host/bus view.
interface bus_ep_if #(parameter int pckg_sz = 16);

    logic [pckg_sz-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic [pckg_sz-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               rx_ovf;

    modport slave (
        input  tx_data, tx_valid, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_data, rx_valid, rx_ovf
    );

    modport master (
        output tx_data, tx_valid, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_data, rx_valid, rx_ovf
    );

endinterface

// File: rtl/bus_ep_fifo.sv
// First-word-fall-through circular FIFO; depth must be a power of two so pointers wrap for free.
module bus_ep_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [width-1:0]             din,
    output logic [width-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth+1);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    cnt;
    logic             wr_en, rd_en;

    assign full  = (cnt == CW'(depth));
    assign empty = (cnt == '0);
    assign count = cnt;

    // Write is refused at full regardless of a same-cycle read; read on empty is a no-op.
    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: TX FIFO toward the bus, RX FIFO toward the host, sticky RX overflow.
// Optional destination filtering on push is enabled by defining BUS_EP_ADDR_FILTER_EN.
module bus_dev_endpoint
    import bus_ep_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] id        = '0,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic      clk,
    input  logic      reset,
    bus_ep_if.slave   bus
);

    localparam int CW = $clog2(depth+1);

`ifdef BUS_EP_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]   tx_cnt, rx_cnt;
    logic [ID_W-1:0] dest;
    logic            addr_hit, accept, rx_ovf_q;

    bus_ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.tx_valid),
        .rd    (bus.pop),
        .din   (bus.tx_data),
        .dout  (bus.D_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt)
    );

    // Without filtering every push is taken; the bus is trusted to route.
    assign dest     = bus.D_push[pckg_sz-1 -: ID_W];
    assign addr_hit = (dest == id) || (dest == broadcast);
    assign accept   = bus.push & (~FILTER_EN | addr_hit);

    bus_ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (accept),
        .rd    (bus.rx_ready),
        .din   (bus.D_push),
        .dout  (bus.rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset)                 rx_ovf_q <= 1'b0;
        else if (accept & rx_full) rx_ovf_q <= 1'b1;
    end

    assign bus.tx_ready = ~tx_full;
    assign bus.pndng    = ~tx_empty;
    assign bus.rx_valid = ~rx_empty;
    assign bus.rx_ovf   = rx_ovf_q;

    a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
        (tx_cnt <= CW'(depth)) && (rx_cnt <= CW'(depth)));

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Scoreboard bench for bus_dev_endpoint: stimulus pushes expected packets, negedge monitors pop and compare.
module tb_bus_dev_endpoint;
    import bus_ep_pkg::*;

    localparam int PW    = 16;
    localparam int DEPTH = 8;
    localparam logic [7:0] MY_ID = 8'h02;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_ep_if #(.pckg_sz(PW)) bif ();

    bus_dev_endpoint #(.pckg_sz(PW), .depth(DEPTH), .id(MY_ID), .broadcast(BROADCAST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    logic [PW-1:0] tx_exp[$];
    logic [PW-1:0] rx_exp[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [PW-1:0] v, input bit expect_accept);
        bif.tx_data  = v;
        bif.tx_valid = 1'b1;
        if (expect_accept) tx_exp.push_back(v);
        tick();
        bif.tx_valid = 1'b0;
    endtask

    task automatic rx_push(input logic [PW-1:0] v, input bit expect_accept);
        bif.D_push = v;
        bif.push   = 1'b1;
        if (expect_accept) rx_exp.push_back(v);
        tick();
        bif.push = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bif.pop = 1'b1;
        repeat (n) tick();
        bif.pop = 1'b0;
    endtask

    function automatic bit filt_ok(input logic [PW-1:0] v);
`ifdef BUS_EP_ADDR_FILTER_EN
        return (dest_of(v) == MY_ID) || (dest_of(v) == BROADCAST);
`else
        return 1'b1;
`endif
    endfunction

    // Monitors: a bus read or host read is consumed at the next posedge; compare its data now.
    always @(negedge clk) begin
        if (mon_en && bif.pop && bif.pndng) begin
            if (tx_exp.size() == 0) check("tx_unexpected_pop", bif.D_pop, 32'hDEAD);
            else                    check("tx_D_pop", bif.D_pop, tx_exp.pop_front());
        end
        if (mon_en && bif.rx_ready && bif.rx_valid) begin
            if (rx_exp.size() == 0) check("rx_unexpected_data", bif.rx_data, 32'hDEAD);
            else                    check("rx_data", bif.rx_data, rx_exp.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bif.tx_data  = '0;
        bif.tx_valid = 1'b0;
        bif.pop      = 1'b0;
        bif.push     = 1'b0;
        bif.D_push   = '0;
        bif.rx_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        mon_en = 1'b1;

        check("rst_pndng",    bif.pndng,    0);
        check("rst_D_pop",    bif.D_pop,    0);
        check("rst_tx_ready", bif.tx_ready, 1);
        check("rst_rx_valid", bif.rx_valid, 0);
        check("rst_rx_data",  bif.rx_data,  0);
        check("rst_rx_ovf",   bif.rx_ovf,   0);

        // TX basic
        tx_write(16'h0312, 1);
        check("basic_pndng", bif.pndng, 1);
        check("basic_head0", bif.D_pop, 16'h0312);
        tx_write(16'h0145, 1);
        pop_n(1);
        check("basic_head1", bif.D_pop, 16'h0145);
        pop_n(1);
        check("basic_empty_pndng", bif.pndng, 0);
        check("basic_empty_D_pop", bif.D_pop, 0);

        // TX full, refused 9th write, then two more fill/drain rounds across the wrap
        for (int i = 0; i < DEPTH; i++) tx_write(16'h1000 + 16'(i), 1);
        check("full_tx_ready", bif.tx_ready, 0);
        tx_write(16'h1FFF, 0);
        check("full_still_full", bif.tx_ready, 0);
        pop_n(DEPTH);
        check("full_drained", bif.pndng, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) tx_write(16'h2000 + 16'(r * 16 + i), 1);
            check("wrap_full", bif.tx_ready, 0);
            pop_n(DEPTH);
            check("wrap_drained", bif.pndng, 0);
        end

        // Simultaneous write+pop with 3 entries held: count stays 3
        for (int i = 0; i < 3; i++) tx_write(16'hA000 + 16'(i), 1);
        bif.pop = 1'b1;
        tx_write(16'hA003, 1);
        bif.pop = 1'b0;
        check("sim3_head", bif.D_pop, 16'hA001);
        pop_n(3);
        check("sim3_drained", bif.pndng, 0);

        // Simultaneous write+pop on empty: write kept, pop ignored
        bif.pop = 1'b1;
        tx_write(16'hB000, 1);
        bif.pop = 1'b0;
        check("simE_pndng", bif.pndng, 1);
        check("simE_head",  bif.D_pop, 16'hB000);
        pop_n(1);
        check("simE_drained", bif.pndng, 0);

        // RX overflow
        for (int i = 0; i < DEPTH; i++) rx_push(16'h02C0 + 16'(i), 1);
        check("ovf_rx_valid", bif.rx_valid, 1);
        check("ovf_not_yet",  bif.rx_ovf,   0);
        rx_push(16'h02FF, 0);
        check("ovf_set", bif.rx_ovf, 1);
        bif.rx_ready = 1'b1;
        repeat (DEPTH) tick();
        bif.rx_ready = 1'b0;
        check("ovf_drained", bif.rx_valid, 0);
        check("ovf_sticky",  bif.rx_ovf,   1);

        // Address filter
        rx_push(16'h02AA, filt_ok(16'h02AA));
        rx_push(16'hFFBB, filt_ok(16'hFFBB));
        rx_push(16'h03CC, filt_ok(16'h03CC));
        check("filt_head", bif.rx_data, 16'h02AA);
        bif.rx_ready = 1'b1;
        repeat (4) tick();
        bif.rx_ready = 1'b0;
        check("filt_drained", bif.rx_valid, 0);

        // Reset mid-operation with pop/push active
        for (int i = 0; i < 4; i++) tx_write(16'hC000 + 16'(i), 0);
        rx_push(16'h02D0, 0);
        rx_push(16'h02D1, 0);
        check("pre_rst_pndng",    bif.pndng,    1);
        check("pre_rst_rx_valid", bif.rx_valid, 1);
        mon_en       = 1'b0;
        reset        = 1'b1;
        bif.pop      = 1'b1;
        bif.push     = 1'b1;
        bif.D_push   = 16'h02EE;
        bif.tx_valid = 1'b1;
        bif.tx_data  = 16'hC0FF;
        tick();
        reset        = 1'b0;
        bif.pop      = 1'b0;
        bif.push     = 1'b0;
        bif.tx_valid = 1'b0;
        check("mrst_pndng",    bif.pndng,    0);
        check("mrst_D_pop",    bif.D_pop,    0);
        check("mrst_rx_valid", bif.rx_valid, 0);
        check("mrst_tx_ready", bif.tx_ready, 1);
        check("mrst_rx_ovf",   bif.rx_ovf,   0);
        mon_en = 1'b1;

        tick();
        check("tx_scoreboard_empty", tx_exp.size(), 0);
        check("rx_scoreboard_empty", rx_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
